// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/window widths, 3x3 tap bit offsets and clog2 helper for the sobel pipeline.
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;
  localparam int TAP_TL = 8 * PIX_W;
  localparam int TAP_TM = 7 * PIX_W;
  localparam int TAP_TR = 6 * PIX_W;
  localparam int TAP_ML = 5 * PIX_W;
  localparam int TAP_MM = 4 * PIX_W;
  localparam int TAP_MR = 3 * PIX_W;
  localparam int TAP_BL = 2 * PIX_W;
  localparam int TAP_BM = 1 * PIX_W;
  localparam int TAP_BR = 0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel stream in, packed 3x3 window out.
interface sobel_window_gen_if;
  import sobel_pkg::*;
  logic [PIX_W-1:0] pix_in;
  logic pix_valid;
  logic [WIN_W-1:0] mem_bus_out;
  logic win_valid;
  modport master (output pix_in, pix_valid, input mem_bus_out, win_valid);
  modport slave (input pix_in, pix_valid, output mem_bus_out, win_valid);
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: circular RAM with one shared read/write pointer giving a DEPTH-sample delay.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  assign dout_o = mem_q[ptr_q];
  always_comb ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (en_i) ptr_q <= ptr_d;
  end
  // RAM contents survive reset; row gating upstream keeps stale data from being emitted
  always_ff @(posedge clk) begin
    if (en_i) mem_q[ptr_q] <= din_i;
  end
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: line-buffered 3x3 window generator feeding main_sobel.
// Optional frame_done output enabled by SOBEL_FRAME_DONE_EN.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = 256,
  parameter int IMG_HEIGHT = 256,
  localparam int CW = clog2(IMG_WIDTH),
  localparam int RW = clog2(IMG_HEIGHT)
) (
  input  logic clk,
  input  logic rst,
  sobel_window_gen_if.slave bus,
`ifdef SOBEL_FRAME_DONE_EN
  output logic frame_done,
`endif
  output logic [CW-1:0] col_cnt,
  output logic [RW-1:0] row_cnt
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PIX_W-1:0] lb1_out, lb0_out;
  logic [2*PIX_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic wv_q, col_end, row_end, emit;
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .en_i(bus.pix_valid), .din_i(bus.pix_in), .dout_o(lb1_out)
  );
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .en_i(bus.pix_valid), .din_i(lb1_out), .dout_o(lb0_out)
  );
  always_comb begin
    col_end = col_q == CW'(IMG_WIDTH - 1);
    row_end = row_q == RW'(IMG_HEIGHT - 1);
    col_d = col_end ? '0 : col_q + 1'b1;
    row_d = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
    emit = bus.pix_valid && row_q >= RW'(2) && col_q >= CW'(2);
    top_d = {top_q[PIX_W-1:0], lb0_out};
    mid_d = {mid_q[PIX_W-1:0], lb1_out};
    bot_d = {bot_q[PIX_W-1:0], bus.pix_in};
    win_d = {top_q, lb0_out, mid_q, lb1_out, bot_q, bus.pix_in};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
      win_q <= '0;
      wv_q <= 1'b0;
    end else begin
      wv_q <= emit;
      if (emit) win_q <= win_d;
      if (bus.pix_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        top_q <= top_d;
        mid_q <= mid_d;
        bot_q <= bot_d;
      end
    end
  end
`ifdef SOBEL_FRAME_DONE_EN
  logic fd_q;
  always_ff @(posedge clk) begin
    if (rst) fd_q <= 1'b0;
    else fd_q <= emit && col_end && row_end;
  end
  assign frame_done = fd_q;
`endif
  assign bus.mem_bus_out = win_q;
  assign bus.win_valid = wv_q;
  assign col_cnt = col_q;
  assign row_cnt = row_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed stream tests with a 2D-image scoreboard for sobel_window_gen.
module tb_sobel_window_gen;
  logic clk = 1'b0, rst;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  sobel_window_gen_if bus ();
  sobel_window_gen_if b2 ();
  logic [1:0] col_cnt, row_cnt;
  logic [3:0] col2;
  logic [2:0] row2;
`ifdef SOBEL_FRAME_DONE_EN
  logic frame_done, fd2;
`endif
  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
`ifdef SOBEL_FRAME_DONE_EN
    .frame_done(frame_done),
`endif
    .col_cnt(col_cnt), .row_cnt(row_cnt)
  );
  sobel_window_gen #(.IMG_WIDTH(16), .IMG_HEIGHT(8)) dut2 (
    .clk(clk), .rst(rst), .bus(b2),
`ifdef SOBEL_FRAME_DONE_EN
    .frame_done(fd2),
`endif
    .col_cnt(col2), .row_cnt(row2)
  );
  logic [7:0] img [0:3][0:3];
  logic [71:0] q [$];
  logic [71:0] last_obs, first2, last2, exp_w;
  int mr, mc, nwin, n2;
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  task automatic cycle(input logic v, input logic [7:0] p);
    logic ew, efd;
    ew = 1'b0;
    efd = 1'b0;
    bus.pix_valid = v;
    bus.pix_in = p;
    if (v) begin
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        q.push_back({img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                     img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                     img[mr][mc-2], img[mr][mc-1], img[mr][mc]});
        ew = 1'b1;
      end
      efd = (mr == 3 && mc == 3);
      mc = (mc == 3) ? 0 : mc + 1;
      if (mc == 0) mr = (mr == 3) ? 0 : mr + 1;
    end
    @(posedge clk);
    #1;
    chk("win_valid", bus.win_valid, ew);
    if (bus.win_valid === 1'b1) begin
      nwin++;
      last_obs = bus.mem_bus_out;
      if (q.size() == 0) chk("unexpected_window", bus.mem_bus_out, 72'h0);
      else begin
        exp_w = q.pop_front();
        chk("window", bus.mem_bus_out, exp_w);
      end
    end
    chk("col_cnt", col_cnt, mc);
    chk("row_cnt", row_cnt, mr);
`ifdef SOBEL_FRAME_DONE_EN
    chk("frame_done", frame_done, efd);
`endif
    bus.pix_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_in = 8'hff;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", bus.mem_bus_out, 72'h0);
    chk("rst_win_valid", bus.win_valid, 1'b0);
    chk("rst_col", col_cnt, 0);
    chk("rst_row", row_cnt, 0);
`ifdef SOBEL_FRAME_DONE_EN
    chk("rst_frame_done", frame_done, 1'b0);
`endif
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    mr = 0;
    mc = 0;
    nwin = 0;
    q.delete();
  endtask
  initial begin
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    b2.pix_valid = 1'b0;
    b2.pix_in = '0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i));
      if (i == 10) chk("first_window", last_obs, 72'h00_01_02_04_05_06_08_09_0A);
    end
    chk("frame1_count", nwin, 4);
    chk("frame1_last", last_obs, 72'h05_06_07_09_0A_0B_0D_0E_0F);
    repeat (3) cycle(1'b0, 8'h55);
    nwin = 0;
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 1) == 1) cycle(1'b0, 8'($urandom));
      cycle(1'b1, 8'(i));
    end
    chk("gaps_count", nwin, 4);
    chk("gaps_last", last_obs, 72'h05_06_07_09_0A_0B_0D_0E_0F);
    nwin = 0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i));
    chk("b2b_f1_count", nwin, 4);
    nwin = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(8'h80 + i));
      if (i == 10) chk("f2_first", last_obs, 72'h80_81_82_84_85_86_88_89_8A);
    end
    chk("b2b_f2_count", nwin, 4);
    chk("f2_last", last_obs, 72'h85_86_87_89_8A_8B_8D_8E_8F);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i));
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i));
    chk("post_rst_count", nwin, 4);
    chk("post_rst_last", last_obs, 72'h25_26_27_29_2A_2B_2D_2E_2F);
    n2 = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        b2.pix_valid = 1'b1;
        b2.pix_in = 8'(16 * r + c);
        @(posedge clk);
        #1;
        if (b2.win_valid === 1'b1) begin
          if (n2 == 0) first2 = b2.mem_bus_out;
          last2 = b2.mem_bus_out;
          n2++;
        end
      end
    b2.pix_valid = 1'b0;
    chk("wide_count", n2, 84);
    chk("wide_first", first2, 72'h00_01_02_10_11_12_20_21_22);
    chk("wide_last", last2, 72'h5D_5E_5F_6D_6E_6F_7D_7E_7F);
    chk("wide_col_wrap", col2, 0);
    chk("wide_row_wrap", row2, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
